// File: rtl/kmap_pkg.sv
// kmap_pkg: shared constants and FSM state type for the K-map sweep controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package kmap_pkg;

  localparam int N_IN    = 4;   // inputs of the function block under sweep
  localparam int N_CODES = 16;  // 2**N_IN input codes per sweep
  localparam int MM_W    = 5;   // mismatch counter width, holds 0..16
  localparam int CNT_W   = 4;   // settle counter width, SETTLE_CYCLES up to 15

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/kmap_sweep_ctrl.sv
// kmap_sweep_ctrl: drives all 16 codes into an external 4-input function block, captures its truth
//   table and counts mismatches against an expected table on cared codes.
// Latency: done pulses 16*(SETTLE_CYCLES+1)+1 cycles after the start-accepting edge.
// Backpressure: none; start is only honoured in IDLE and is dropped (not queued) while busy.
// Ports:
//   clk, reset          - sole clock, synchronous active-high reset
//   start, abort        - begin a sweep (IDLE only) / cancel a sweep in DRIVE or SAMPLE
//   f_in                - output of the function block for the code on x_out
//   exp_tt, care_mask   - expected table and care bits, indexed by code
//   x_out               - code presented to the function block
//   busy, done          - not-IDLE flag, one-cycle completion pulse
//   tt, mismatch_cnt    - captured table and cared-mismatch count
//   pass                - last completed sweep had no mismatches
module kmap_sweep_ctrl
  import kmap_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1  // 1..15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               f_in,
  input  logic [N_CODES-1:0] exp_tt,
  input  logic [N_CODES-1:0] care_mask,
  output logic [N_IN-1:0]    x_out,
  output logic               busy,
  output logic               done,
  output logic [N_CODES-1:0] tt,
  output logic [MM_W-1:0]    mismatch_cnt,
  output logic               pass
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0]  LAST_CODE   = N_IN'(N_CODES - 1);

  state_e             state_q;
  logic [N_IN-1:0]    x_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic [N_CODES-1:0] tt_q;
  logic [MM_W-1:0]    mm_q;

  logic               settle_end_d;
  logic               miss_d;
  logic [MM_W-1:0]    mm_d;

  always_comb begin
    settle_end_d = (cnt_q == SETTLE_LAST);
    // Case inequality so an X/Z from the block under test counts as a miss in
    // simulation; synthesis reduces it to an ordinary compare.
    miss_d       = care_mask[x_q] && (f_in !== exp_tt[x_q]);
    mm_d         = mm_q + MM_W'(miss_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      tt_q    <= '0;
      mm_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          // start beats a simultaneous abort; abort alone does nothing here.
          if (start) begin
            state_q <= ST_DRIVE;
            busy_q  <= 1'b1;
            x_q     <= '0;
            cnt_q   <= '0;
            tt_q    <= '0;
            mm_q    <= '0;
            pass_q  <= 1'b0;
          end
        end

        ST_DRIVE: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            x_q     <= '0;
            cnt_q   <= '0;
          end else if (settle_end_d) begin
            state_q <= ST_SAMPLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_SAMPLE: begin
          // An abort here wins over the capture as well as the transition,
          // so tt/mismatch_cnt stay at their values for the codes already done.
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
            x_q     <= '0;
            cnt_q   <= '0;
          end else begin
            tt_q[x_q] <= f_in;
            mm_q      <= mm_d;
            if (x_q == LAST_CODE) begin
              // x_out stays on the last code; no wrap back to 0.
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_DRIVE;
              x_q     <= x_q + 1'b1;
              cnt_q   <= '0;
            end
          end
        end

        ST_DONE: begin
          // start and abort are both ignored in this cycle.
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          pass_q  <= (mm_q == '0);
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign x_out        = x_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign tt           = tt_q;
  assign mismatch_cnt = mm_q;
  assign pass         = pass_q;

endmodule

// File: tb/tb_kmap_sweep_ctrl.sv
// tb_kmap_sweep_ctrl: self-checking bench for kmap_sweep_ctrl (SETTLE_CYCLES=1 and =3 instances).
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_kmap_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset, start1, start3, abort;
  logic [15:0] exp_tt, care_mask;
  logic        f1, f3;
  logic [3:0]  x1, x3;
  logic        busy1, busy3, done1, done3, pass1, pass3;
  logic [15:0] tt1, tt3;
  logic [4:0]  mm1, mm3;

  // Function block configuration: base table, forced-one codes, inverted codes, one X code.
  logic [15:0] func_tt, one_mask, inv_mask;
  logic        xen;
  logic [3:0]  xcode;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  kmap_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort), .f_in(f1),
    .exp_tt(exp_tt), .care_mask(care_mask), .x_out(x1), .busy(busy1), .done(done1),
    .tt(tt1), .mismatch_cnt(mm1), .pass(pass1)
  );

  kmap_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .abort(abort), .f_in(f3),
    .exp_tt(exp_tt), .care_mask(care_mask), .x_out(x3), .busy(busy3), .done(done3),
    .tt(tt3), .mismatch_cnt(mm3), .pass(pass3)
  );

  // External function blocks, one per DUT.
  always_comb begin
    f1 = func_tt[x1] ^ inv_mask[x1];
    if (one_mask[x1]) f1 = 1'b1;
    if (xen && (x1 == xcode)) f1 = 1'bx;
  end

  always_comb begin
    f3 = func_tt[x3] ^ inv_mask[x3];
    if (one_mask[x3]) f3 = 1'b1;
    if (xen && (x3 == xcode)) f3 = 1'bx;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: DUT event not seen within cycle budget", name);
  endtask

  // Reference: value the block under test gives for a code.
  function automatic logic fval(input logic [3:0] c);
    logic v;
    v = func_tt[c] ^ inv_mask[c];
    if (one_mask[c]) v = 1'b1;
    if (xen && (c == xcode)) v = 1'bx;
    return v;
  endfunction

  // Reference sweep over codes 0..upto-1: captured table and cared mismatches.
  task automatic model(input int upto, output logic [15:0] t, output int mm);
    t  = '0;
    mm = 0;
    for (int c = 0; c < upto; c++) begin
      logic v;
      v    = fval(4'(c));
      t[c] = v;
      if (care_mask[c] && (v !== exp_tt[c])) mm++;
    end
  endtask

  // One full sweep on the SETTLE_CYCLES=1 instance. dc = cycle (edge 0 = accept) in which done
  // is first high, nd = number of done cycles seen.
  task automatic run_sweep1(output int dc, output int nd);
    dc = -1;
    nd = 0;
    @(negedge clk);
    start1 = 1'b1;
    for (int e = 0; e < 200; e++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (done1 === 1'b1) begin
        nd++;
        if (dc < 0) dc = e + 1;
      end
      if (dc >= 0 && e >= dc + 2) break;
    end
    if (dc < 0) fail_now("sweep_done");
  endtask

  task automatic wait_x1(input logic [3:0] code, output bit found);
    found = 1'b0;
    for (int e = 0; e < 100; e++) begin
      if (x1 == code) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic set_golden();
    func_tt   = 16'h5850;
    one_mask  = 16'h0000;
    inv_mask  = 16'h0000;
    xen       = 1'b0;
    xcode     = 4'd0;
    exp_tt    = 16'h5850;
    care_mask = 16'h5BD4;
  endtask

  typedef struct {
    logic [15:0] func;
    logic [15:0] one;
    logic [15:0] inv;
    logic        xen;
    logic [3:0]  xc;
    int          mm;
    logic        pass;
  } vec_t;

  vec_t vt[4];

  initial begin
    logic [15:0] mt;
    int          mmm, dc, nd, nsteps;
    logic [3:0]  px;
    bit          found;

    // golden, don't-care codes forced to 1, codes 4/8 inverted, X on code 2
    vt[0] = '{16'h5850, 16'h0000, 16'h0000, 1'b0, 4'd0, 0, 1'b1};
    vt[1] = '{16'h5850, 16'hA42B, 16'h0000, 1'b0, 4'd0, 0, 1'b1};
    vt[2] = '{16'h5850, 16'h0000, 16'h0110, 1'b0, 4'd0, 2, 1'b0};
    vt[3] = '{16'h5850, 16'h0000, 16'h0000, 1'b1, 4'd2, 1, 1'b0};

    reset  = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    abort  = 1'b0;
    set_golden();
    repeat (3) @(negedge clk);

    chk("rst_x1", x1, 0);       chk("rst_busy1", busy1, 0); chk("rst_done1", done1, 0);
    chk("rst_tt1", tt1, 0);     chk("rst_mm1", mm1, 0);     chk("rst_pass1", pass1, 0);
    chk("rst_x3", x3, 0);       chk("rst_busy3", busy3, 0); chk("rst_done3", done3, 0);
    chk("rst_tt3", tt3, 0);     chk("rst_mm3", mm3, 0);     chk("rst_pass3", pass3, 0);
    reset = 1'b0;

    // Table-driven sweeps
    for (int i = 0; i < 4; i++) begin
      func_tt   = vt[i].func;
      one_mask  = vt[i].one;
      inv_mask  = vt[i].inv;
      xen       = vt[i].xen;
      xcode     = vt[i].xc;
      exp_tt    = 16'h5850;
      care_mask = 16'h5BD4;
      model(16, mt, mmm);
      run_sweep1(dc, nd);
      chk("vec_done_cycle", dc, 33);
      chk("vec_done_count", nd, 1);
      chk("vec_tt", tt1, mt);
      if (vt[i].xen) begin
        // X resolves per simulator semantics; the reference sees the same value.
        chk("vec_mm", mm1, mmm);
        chk("vec_pass", pass1, (mmm == 0));
      end else begin
        chk("vec_mm", mm1, vt[i].mm);
        chk("vec_pass", pass1, vt[i].pass);
      end
      chk("vec_busy_after", busy1, 0);
      chk("vec_x_end", x1, 15);
    end

    // Abort during DRIVE of code 6, after a passing sweep
    set_golden();
    run_sweep1(dc, nd);
    chk("pre_abort_pass", pass1, 1);
    inv_mask = 16'h0010;
    model(6, mt, mmm);
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_x1(4'd6, found);
    if (!found) fail_now("abort_reach_code6");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy1, 0);
    chk("abort_done", done1, 0);
    chk("abort_pass", pass1, 0);
    chk("abort_x", x1, 0);
    chk("abort_mm_partial", mm1, mmm);
    chk("abort_tt_partial", tt1, mt);
    nd = 0;
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      if (done1 === 1'b1) nd++;
    end
    chk("abort_no_done", nd, 0);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("restart_tt_clr", tt1, 0);
    chk("restart_mm_clr", mm1, 0);
    chk("restart_busy", busy1, 1);
    for (int e = 0; e < 60 && busy1; e++) @(negedge clk);

    // start pulses during a sweep and during DONE are dropped
    set_golden();
    @(negedge clk);
    start1 = 1'b1;
    nd = 0;
    for (int e = 0; e < 150; e++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (e == 10) start1 = 1'b1;
      if (done1 === 1'b1) begin
        nd++;
        start1 = 1'b1;
      end
    end
    start1 = 1'b0;
    chk("ignore_start_dones", nd, 1);
    chk("ignore_start_busy", busy1, 0);

    // Reset mid-sweep at code 9
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_x1(4'd9, found);
    if (!found) fail_now("reset_reach_code9");
    reset = 1'b1;
    abort = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    abort = 1'b0;
    start1 = 1'b0;
    chk("mid_rst_x", x1, 0);     chk("mid_rst_busy", busy1, 0); chk("mid_rst_done", done1, 0);
    chk("mid_rst_tt", tt1, 0);   chk("mid_rst_mm", mm1, 0);     chk("mid_rst_pass", pass1, 0);
    nd = 0;
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      if (done1 === 1'b1) nd++;
    end
    chk("mid_rst_no_done", nd, 0);

    // SETTLE_CYCLES=3: one code step per 4 cycles, done in cycle 65
    set_golden();
    model(16, mt, mmm);
    @(negedge clk);
    start3 = 1'b1;
    px     = 4'd0;
    dc     = -1;
    nsteps = 0;
    for (int e = 0; e < 300; e++) begin
      @(negedge clk);
      start3 = 1'b0;
      if (x3 != px) begin
        nsteps++;
        chk("s3_step_edge", e, 4 * int'(x3));
        px = x3;
      end
      if (done3 === 1'b1 && dc < 0) dc = e + 1;
      if (dc >= 0 && e >= dc + 2) break;
    end
    if (dc < 0) fail_now("s3_done");
    chk("s3_done_cycle", dc, 65);
    chk("s3_steps", nsteps, 15);
    chk("s3_x_end", x3, 15);
    chk("s3_tt", tt3, mt);
    chk("s3_mm", mm3, mmm);
    chk("s3_pass", pass3, 1);

    // Random tables against the reference
    for (int r = 0; r < 6; r++) begin
      func_tt   = 16'($urandom);
      exp_tt    = 16'($urandom);
      care_mask = 16'($urandom);
      one_mask  = '0;
      inv_mask  = '0;
      xen       = 1'b0;
      model(16, mt, mmm);
      run_sweep1(dc, nd);
      chk("rnd_done_cycle", dc, 33);
      chk("rnd_tt", tt1, mt);
      chk("rnd_mm", mm1, mmm);
      chk("rnd_pass", pass1, (mmm == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
